control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the register-bus datapath's control strobes.
- It walks each instruction through a fixed T-state sequence: fetch, decode, then a three-step register-register ALU execute.
- It decodes the instruction word held in IR and emits one-hot register in/out selects, memory-read and PC-update strobes, and an ALU opcode.
- Memory reads are stretched by a ready handshake.

Parameters:
- NUM_REGS, 16, number of general registers; width of rin/rout one-hot vectors.
- OPW, 5, opcode field width (ir[31:27]).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; clears sequencer on the next rising edge
- run  input  1  level; sequencer leaves IDLE only while high
- ir  input  32  current IR contents
- mem_ready  input  1  memory has valid Mdatain this cycle
- PCout, MARin, IncPC, Zin, Zlowout, PCin  output  1 each  datapath strobes
- Read, MDRin, MDRout, IRin, Yin  output  1 each  datapath strobes
- rout  output  NUM_REGS  one-hot general-register bus-drive select
- rin  output  NUM_REGS  one-hot general-register load select
- alu_op  output  OPW  ALU function; valid only while Zin=1 in T4
- halted  output  1  high while in HALT
- busy  output  1  high in any state except IDLE and HALT

Behaviour:
- State register only; all outputs are a combinational decode of state, ir and mem_ready. There are no output registers.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. Encoding is free.
- Reset: state becomes IDLE on the next rising edge. In IDLE all strobes, rin and rout are 0, alu_op=0, halted=0, busy=0. Reset overrides every state, including T1 mid-wait and HALT.
- IDLE: run=1 moves to T0; otherwise the sequencer stays in IDLE.
- T0: PCout=MARin=IncPC=Zin=1. Next state is T1.
- T1 (memory read):
  - Read=1 every cycle spent in T1.
  - If mem_ready=0: hold in T1 with all other strobes 0.
  - If mem_ready=1: assert MDRin=Zlowout=PCin=1 for that cycle only, then go to T2.
  - PCin pulses exactly once per fetch regardless of the number of wait cycles.
- T2: MDRout=IRin=1. Next state is T3.
- Decode in T3..T5 uses the IR value already latched at the end of T2:
  - op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- Opcode set: ADD=5'b00011, SUB=5'b00100, AND=5'b00101, OR=5'b00110, HALT=5'b11011. Every other opcode is a NOP.
- T3:
  - ALU op: rout=1<<rb, Yin=1, next state T4.
  - NOP: no strobes; next state is T0 if run=1, else IDLE.
  - HALT: no strobes, next state HALT.
- T4: rout=1<<rc, Zin=1, alu_op=op. Next state is T5.
- T5: Zlowout=1, rin=1<<ra. Next state is T0 if run=1, else IDLE.
- run is sampled only in IDLE, at NOP T3 and at T5. Deasserting run mid-instruction completes the current instruction.
- HALT: halted=1, all strobes 0. The sequencer stays in HALT until reset; run is ignored.
- Aliasing: ra=rb=rc is legal, and R0 is writable. Each of rin and rout is either all-zero or exactly one-hot.
- Never both a register rout and another bus driver (PCout, MDRout, Zlowout) in the same cycle.
- busy=1 in T0..T5, including T1 wait cycles.

Test Plan:
- Reset then run=1, mem_ready=1, ir=ADD r5,r2,r4 (0x1A900000 | rc=4 → 0x1A920000) -> T0..T5 take exactly 6 cycles. Required strobes:
  - T3: rout=0x0004, Yin=1.
  - T4: rout=0x0010, alu_op=3, Zin=1.
  - T5: rin=0x0020, Zlowout=1.
  - Next cycle is T0.
- Fetch with mem_ready low for 3 cycles -> Read=1 for 4 consecutive cycles. MDRin, PCin and Zlowout are high only on the 4th cycle; IRin follows in the next cycle.
- ir opcode 5'b11011 -> after T3, halted=1, busy=0, all strobes 0 for 20 cycles with run=1. Asserting reset returns the sequencer to IDLE with halted=0.
- Undefined opcode (5'b01111) -> T3 emits no strobes; with run=1 the next cycle is T0 (4-cycle instruction).
- run dropped during T4 of SUB -> T5 completes with rin asserted and alu_op=4 seen in T4, then IDLE. No T0 occurs until run=1.
- reset asserted during the T1 wait state -> next cycle is IDLE with Read=0. A later run=1 restarts cleanly at T0.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control-strobe bundle between the hardwired sequencer (master) and the register-bus datapath (slave).
interface control_sequencer_if #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned OPW      = 5
);
    logic [31:0]         ir;
    logic                mem_ready;

    logic                PCout;
    logic                MARin;
    logic                IncPC;
    logic                Zin;
    logic                Zlowout;
    logic                PCin;
    logic                Read;
    logic                MDRin;
    logic                MDRout;
    logic                IRin;
    logic                Yin;
    logic [NUM_REGS-1:0] rout;
    logic [NUM_REGS-1:0] rin;
    logic [OPW-1:0]      alu_op;
    logic                halted;
    logic                busy;

    modport master (
        input  ir, mem_ready,
        output PCout, MARin, IncPC, Zin, Zlowout, PCin,
        output Read, MDRin, MDRout, IRin, Yin,
        output rout, rin, alu_op, halted, busy
    );

    modport slave (
        output ir, mem_ready,
        input  PCout, MARin, IncPC, Zin, Zlowout, PCin,
        input  Read, MDRin, MDRout, IRin, Yin,
        input  rout, rin, alu_op, halted, busy
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch, decode, three-step register-register ALU execute.
// Only the state is registered; every strobe is a combinational decode of state, ir and mem_ready.
module control_sequencer #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned OPW      = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    control_sequencer_if.master bus
);
    localparam int unsigned REG_IDX_W = 4;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [OPW-1:0]       op;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
    logic                 is_alu;
    logic                 ir_unused;

    // Instruction fields; the low IR bits carry no control information.
    assign op        = OPW'(bus.ir[31:27]);
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign ir_unused = ^bus.ir[14:0];

    assign is_alu = (op == OP_ADD) || (op == OP_SUB) ||
                    (op == OP_AND) || (op == OP_OR);

    // State register; reset wins over every state, including T1 waits and HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_nx    = state;
        bus.PCout   = 1'b0;
        bus.MARin   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Zin     = 1'b0;
        bus.Zlowout = 1'b0;
        bus.PCin    = 1'b0;
        bus.Read    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.rout    = '0;
        bus.rin     = '0;
        bus.alu_op  = '0;
        bus.halted  = 1'b0;
        bus.busy    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_T0;
                end
            end
            S_T0: begin
                bus.busy  = 1'b1;
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                state_nx  = S_T1;
            end
            S_T1: begin
                // Read is held across wait cycles; PC update fires only on the ready cycle.
                bus.busy = 1'b1;
                bus.Read = 1'b1;
                if (bus.mem_ready) begin
                    bus.MDRin   = 1'b1;
                    bus.Zlowout = 1'b1;
                    bus.PCin    = 1'b1;
                    state_nx    = S_T2;
                end
            end
            S_T2: begin
                bus.busy   = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_nx   = S_T3;
            end
            S_T3: begin
                bus.busy = 1'b1;
                if (is_alu) begin
                    bus.rout = NUM_REGS'(1) << rb;
                    bus.Yin  = 1'b1;
                    state_nx = S_T4;
                end else if (op == OP_HALT) begin
                    state_nx = S_HALT;
                end else begin
                    state_nx = run ? S_T0 : S_IDLE;
                end
            end
            S_T4: begin
                bus.busy   = 1'b1;
                bus.rout   = NUM_REGS'(1) << rc;
                bus.Zin    = 1'b1;
                bus.alu_op = op;
                state_nx   = S_T5;
            end
            S_T5: begin
                bus.busy    = 1'b1;
                bus.Zlowout = 1'b1;
                bus.rin     = NUM_REGS'(1) << ra;
                state_nx    = run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe vectors compared against hand-derived values.
module tb_control_sequencer;
    logic clk;
    logic reset;
    logic run;
    int   checks;
    int   failures;

    control_sequencer_if #(.NUM_REGS(16), .OPW(5)) bus ();

    control_sequencer #(.NUM_REGS(16), .OPW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCout,MARin,IncPC,Zin,Zlowout,PCin,Read,MDRin,MDRout,IRin,Yin}, rout, rin, alu_op, busy, halted
    logic [10:0] stb;
    logic [49:0] obs;
    assign stb = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.PCin,
                  bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin};
    assign obs = {stb, bus.rout, bus.rin, bus.alu_op, bus.busy, bus.halted};

    localparam logic [49:0] V_IDLE = 50'd0;
    localparam logic [49:0] V_T0   = {11'h780, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};
    localparam logic [49:0] V_T1W  = {11'h010, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};
    localparam logic [49:0] V_T1R  = {11'h078, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};
    localparam logic [49:0] V_T2   = {11'h006, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};
    localparam logic [49:0] V_T3N  = {11'h000, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0};
    localparam logic [49:0] V_HALT = {11'h000, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1};

    // ADD r5,r2,r4
    localparam logic [49:0] V_ADD3 = {11'h001, 16'h0004, 16'h0000, 5'd0, 1'b1, 1'b0};
    localparam logic [49:0] V_ADD4 = {11'h080, 16'h0010, 16'h0000, 5'd3, 1'b1, 1'b0};
    localparam logic [49:0] V_ADD5 = {11'h040, 16'h0000, 16'h0020, 5'd0, 1'b1, 1'b0};
    // SUB r7,r1,r9
    localparam logic [49:0] V_SUB3 = {11'h001, 16'h0002, 16'h0000, 5'd0, 1'b1, 1'b0};
    localparam logic [49:0] V_SUB4 = {11'h080, 16'h0200, 16'h0000, 5'd4, 1'b1, 1'b0};
    localparam logic [49:0] V_SUB5 = {11'h040, 16'h0000, 16'h0080, 5'd0, 1'b1, 1'b0};

    localparam logic [31:0] IR_ADD  = 32'h1A92_0000;
    localparam logic [31:0] IR_SUB  = 32'h238C_8000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_NOP  = 32'h7800_0000;

    task automatic test_reset();
        reset         = 1'b1;
        run           = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir        = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (i >= 1) begin
                checks++;
                if (obs !== V_IDLE) begin
                    failures++;
                    $display("FAIL reset cyc=%0d obs=%h exp=%h", i, obs, V_IDLE);
                end
            end
            if (i == 1) reset = 1'b0;
        end
    endtask

    task automatic test_add();
        logic [49:0] e [14];
        e = '{V_IDLE, V_T0, V_T1R, V_T2, V_ADD3, V_ADD4, V_ADD5,
              V_T0, V_T1R, V_T2, V_ADD3, V_ADD4, V_ADD5, V_IDLE};
        bus.ir        = IR_ADD;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL add cyc=%0d obs=%h exp=%h", i, obs, e[i]);
            end
            if (i == 0) run = 1'b1;
            if (i == 7) run = 1'b0;
        end
    endtask

    task automatic test_mem_wait();
        logic [49:0] e [11];
        e = '{V_IDLE, V_T0, V_T1W, V_T1W, V_T1W, V_T1R, V_T2,
              V_ADD3, V_ADD4, V_ADD5, V_IDLE};
        bus.ir = IR_ADD;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.mem_ready = (i >= 5);
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL mem_wait cyc=%0d obs=%h exp=%h", i, obs, e[i]);
            end
            if (i == 0) run = 1'b1;
            if (i == 1) run = 1'b0;
        end
    endtask

    task automatic test_halt();
        logic [49:0] e [27];
        for (int k = 0; k < 27; k++) e[k] = V_HALT;
        e[0]  = V_IDLE;
        e[1]  = V_T0;
        e[2]  = V_T1R;
        e[3]  = V_T2;
        e[4]  = V_T3N;
        e[25] = V_IDLE;
        e[26] = V_IDLE;
        bus.ir        = IR_HALT;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL halt cyc=%0d obs=%h exp=%h", i, obs, e[i]);
            end
            if (i == 0) run = 1'b1;
            if (i == 24) reset = 1'b1;
            if (i == 25) begin
                reset = 1'b0;
                run   = 1'b0;
            end
        end
    endtask

    task automatic test_nop();
        logic [49:0] e [10];
        e = '{V_IDLE, V_T0, V_T1R, V_T2, V_T3N, V_T0, V_T1R, V_T2, V_T3N, V_IDLE};
        bus.ir        = IR_NOP;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL nop cyc=%0d obs=%h exp=%h", i, obs, e[i]);
            end
            if (i == 0) run = 1'b1;
            if (i == 5) run = 1'b0;
        end
    endtask

    task automatic test_run_drop();
        logic [49:0] e [17];
        e = '{V_IDLE, V_T0, V_T1R, V_T2, V_SUB3, V_SUB4, V_SUB5, V_IDLE, V_IDLE, V_IDLE,
              V_T0, V_T1R, V_T2, V_SUB3, V_SUB4, V_SUB5, V_IDLE};
        bus.ir        = IR_SUB;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL run_drop cyc=%0d obs=%h exp=%h", i, obs, e[i]);
            end
            if (i == 0) run = 1'b1;
            if (i == 5) run = 1'b0;
            if (i == 9) run = 1'b1;
            if (i == 10) run = 1'b0;
        end
    endtask

    task automatic test_reset_wait();
        logic [49:0] e [12];
        e = '{V_IDLE, V_T0, V_T1W, V_T1W, V_IDLE, V_T0, V_T1R, V_T2,
              V_ADD3, V_ADD4, V_ADD5, V_IDLE};
        bus.ir = IR_ADD;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.mem_ready = (i >= 6);
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL reset_wait cyc=%0d obs=%h exp=%h", i, obs, e[i]);
            end
            if (i == 0) run = 1'b1;
            if (i == 3) reset = 1'b1;
            if (i == 4) reset = 1'b0;
            if (i == 5) run = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_mem_wait();
        test_halt();
        test_nop();
        test_run_drop();
        test_reset_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench did not complete");
    end
endmodule
